dma_copy_engine: RTL and testbench

//  Bus initiator for the 256-byte data memory: copies a block of bytes from one address range to another, or fills a range with a constant.

---
 rtl/dma_copy_engine_pkg.sv | 14 +
 rtl/dma_addr_gen.sv | 45 ++++
 rtl/dma_copy_engine.sv | 127 ++++++++++++
 tb/tb_dma_copy_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_copy_engine_pkg.sv
// Shared definitions for the DMA copy/fill engine: FSM state encoding and mode values.
package dma_copy_engine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dma_addr_gen.sv
// Address generator for the DMA engine: latched bases, byte index and remaining count.
module dma_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_byte
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   remaining;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            dst_q     <= '0;
            index     <= '0;
            remaining <= '0;
        end else if (load) begin
            src_q     <= src_base;
            dst_q     <= dst_base;
            index     <= '0;
            remaining <= count;
        end else if (step) begin
            index     <= index + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Sums truncate to ADDR_W bits, so addresses wrap around the top of memory.
    assign rd_addr   = src_q + index;
    assign wr_addr   = dst_q + index;
    assign last_byte = (remaining == (ADDR_W + 1)'(1));

endmodule

// File: rtl/dma_copy_engine.sv
// Data-memory bus initiator: byte-sequential block copy or constant fill, gated by arbiter grant.
import dma_copy_engine_pkg::*;

module dma_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              dma_req,
    input  logic              dma_grant,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state;
    logic              mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] buffer;
    logic              load;
    logic              step;
    logic              last_byte;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign load = (state == IDLE) && start;
    assign step = (state == WR) && dma_grant;

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .src_base  (src_addr),
        .dst_base  (dst_addr),
        .count     (length),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= MODE_COPY;
            fill_q <= '0;
            buffer <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start outranks abort here: abort only cancels an operation in flight.
                    if (start) begin
                        mode_q <= mode;
                        fill_q <= fill_value;
                        busy   <= 1'b1;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= (mode == MODE_FILL) ? WR : RD;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dma_grant) begin
                        buffer <= mem_read_data;
                        state  <= WR;
                    end
                end
                WR: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dma_grant) begin
                        if (last_byte) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= (mode_q == MODE_FILL) ? WR : RD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dma_req   = (state == RD) || (state == WR);
    assign mem_read  = (state == RD) && dma_grant;
    assign mem_write = (state == WR) && dma_grant;

    // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            RD: mem_address = rd_addr;
            WR: begin
                mem_address    = wr_addr;
                mem_write_data = (mode_q == MODE_FILL) ? fill_q : buffer;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: behavioural memory responder plus an access-list model.
module tb_dma_copy_engine;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [8:0] length;
    logic [7:0] fill_value;
    logic       abort;
    logic       busy;
    logic       done;
    logic       dma_req;
    logic       dma_grant;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       pl_init;
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    acc_t exp_q [$];
    acc_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dma_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .fill_value     (fill_value),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .dma_req        (dma_req),
        .dma_grant      (dma_grant),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Data memory responder: combinational read, write on the clock edge.
    assign mem_read_data = mem[mem_address];

    always @(posedge clk) begin
        if (pl_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (mem_write) begin
            mem[mem_address] <= mem_write_data;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic gpat(input int sel, input int t);
        if (sel == 0) return 1'b1;
        return ((t - 1) % 3 == 0);
    endfunction

    function automatic int image_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Every strobe must match the next access the model predicts.
    always @(negedge clk) begin
        if (rst_n && (mem_read || mem_write)) begin
            check("strobe_granted", 32'(dma_grant), 1);
            check("strobe_exclusive", 32'(mem_read & mem_write), 0);
            check("access_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("access_kind", 32'(mem_write), 32'(e.wr));
                check("access_addr", 32'(mem_address), 32'(e.addr));
                if (e.wr) check("write_data", 32'(mem_write_data), 32'(e.data));
            end
        end else if (rst_n && !dma_req) begin
            check("idle_addr_data", 32'({mem_address, mem_write_data}), 0);
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // k limits how many accesses complete (abort/reset); 0 for *_at disables that event.
    task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] len, input logic [7:0] fv, input int sel,
                          input int k, input int abort_at, input int restart_at,
                          input int reset_at, input int lit_done);
        int n, need, tt, exp_done, t_done;
        logic [7:0] a, b, v;
        bit seen;
        n = 0;
        for (int i = 0; i < int'(len); i++) begin
            a = s + 8'(i);
            b = d + 8'(i);
            if (m == 1'b0) begin
                if (n < k) exp_q.push_back('{1'b0, a, 8'h00});
                n++;
                v = ref_mem[a];
            end else begin
                v = fv;
            end
            if (n < k) begin
                exp_q.push_back('{1'b1, b, v});
                ref_mem[b] = v;
            end
            n++;
        end
        need = n; tt = 0;
        while (need > 0) begin
            tt++;
            if (gpat(sel, tt)) need--;
        end
        exp_done = tt + 1;

        @(posedge clk); #1;
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len;
        fill_value = fv; abort = 1'b0; dma_grant = gpat(sel, 0);
        seen = 0; t_done = 0;
        for (int t = 1; t <= 400; t++) begin
            @(posedge clk); #1;
            start = (t == restart_at);
            if (start) begin
                mode = ~m; src_addr = s ^ 8'hFF; dst_addr = d ^ 8'h55;
                length = 9'd7; fill_value = ~fv;
            end
            abort     = (t == abort_at);
            dma_grant = gpat(sel, t);
            if (t == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_outputs_zero",
                      32'({busy, done, dma_req, mem_read, mem_write, mem_address, mem_write_data}), 0);
                break;
            end
            @(negedge clk);
            check("busy_during_op", 32'(busy), 1);
            if (done) begin
                seen = 1; t_done = t;
                check("req_low_in_done", 32'(dma_req), 0);
                break;
            end
            check("req_during_op", 32'(dma_req), 1);
            if (t == abort_at) break;
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; dma_grant = 1'b0;
        check("busy_after", 32'(busy), 0);
        check("done_after", 32'(done), 0);
        if (reset_at > 0) begin
            rst_n = 1'b1;
        end else if (abort_at > 0) begin
            check("no_done_on_abort", 32'(seen), 0);
        end else begin
            check("done_seen", 32'(seen), 1);
            check("done_cycle_model", 32'(t_done), 32'(exp_done));
            if (lit_done >= 0) check("done_cycle_literal", 32'(t_done), 32'(lit_done));
        end
        check("accesses_drained", 32'(exp_q.size()), 0);
        check("mem_image", 32'(image_diffs()), 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; fill_value = '0; abort = 1'b0; dma_grant = 1'b0;
        pl_init = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
        #3 rst_n = 1'b0;
        #1 check("reset_state",
                 32'({busy, done, dma_req, mem_read, mem_write, mem_address, mem_write_data}), 0);
        #18 rst_n = 1'b1;
        pl_init = 1'b0;

        // 1: basic copy
        preload(8'h10, 8'hAA); preload(8'h11, 8'hBB);
        preload(8'h12, 8'hCC); preload(8'h13, 8'hDD);
        run_op(1'b0, 8'h10, 8'h80, 9'd4, 8'h00, 0, 1000, 0, 0, 0, 9);
        check("copy_80", 32'(mem[8'h80]), 32'h00AA);
        check("copy_81", 32'(mem[8'h81]), 32'h00BB);
        check("copy_82", 32'(mem[8'h82]), 32'h00CC);
        check("copy_83", 32'(mem[8'h83]), 32'h00DD);

        // 2: fill wrapping past the top of memory
        run_op(1'b1, 8'h00, 8'hFE, 9'd4, 8'h5A, 0, 1000, 0, 0, 0, 5);
        check("fill_fe", 32'(mem[8'hFE]), 32'h5A);
        check("fill_ff", 32'(mem[8'hFF]), 32'h5A);
        check("fill_00", 32'(mem[8'h00]), 32'h5A);
        check("fill_01", 32'(mem[8'h01]), 32'h5A);

        // 3: grant toggling 1,0,0 vs full grant
        run_op(1'b0, 8'h10, 8'hA0, 9'd3, 8'h00, 1, 1000, 0, 0, 0, 17);
        run_op(1'b0, 8'h10, 8'hB0, 9'd3, 8'h00, 0, 1000, 0, 0, 0, 7);
        for (int i = 0; i < 3; i++)
            check("gated_equals_full", 32'(mem[8'hA0 + 8'(i)]), 32'(mem[8'hB0 + 8'(i)]));

        // 4: forward overlap replicates the head byte
        preload(8'h20, 8'h11); preload(8'h21, 8'h22); preload(8'h22, 8'h33);
        run_op(1'b0, 8'h20, 8'h21, 9'd3, 8'h00, 0, 1000, 0, 0, 0, 7);
        check("overlap_21", 32'(mem[8'h21]), 32'h11);
        check("overlap_22", 32'(mem[8'h22]), 32'h11);
        check("overlap_23", 32'(mem[8'h23]), 32'h11);

        // 5: abort after the second write, with a start while busy
        run_op(1'b0, 8'h40, 8'h90, 9'd8, 8'h00, 0, 5, 5, 3, 0, -1);
        check("abort_91_written", 32'(mem[8'h91]), 32'h7D);
        check("abort_92_untouched", 32'(mem[8'h92]), 32'hAE);

        // 6: zero length, then reset mid-fill, then a normal fill
        run_op(1'b0, 8'h10, 8'h60, 9'd0, 8'h00, 0, 1000, 0, 0, 0, 1);
        run_op(1'b1, 8'h00, 8'hC0, 9'd10, 8'h77, 0, 3, 0, 0, 4, -1);
        check("reset_c2_written", 32'(mem[8'hC2]), 32'h77);
        check("reset_c3_untouched", 32'(mem[8'hC3]), 32'hFF);
        run_op(1'b1, 8'h00, 8'hC8, 9'd2, 8'h99, 0, 1000, 0, 0, 0, 3);
        check("post_reset_fill", 32'(mem[8'hC9]), 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
